// File: rtl/redirect_sequencer.sv
// redirect_sequencer: arbitrates pipeline redirect sources (exception, ertn,
// branch mispredict), flushes the affected stages for one cycle and then offers
// the new fetch PC on a valid/ready handshake until fetch accepts it.
//
// Optional feature: define REDIRECT_STAT_EN to add per-source transfer counters
// (stat_bp, stat_exp, stat_ertn) and a fetch-hold cycle counter (stat_hold).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module redirect_sequencer #(
   parameter int unsigned ADDR_W = `ADDR_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bp_miss,
   input  logic [ADDR_W-1:0] bp_target,
   input  logic              exp_en,
   input  logic [ADDR_W-1:0] trap_entry,
   input  logic              e_ret,
   input  logic [ADDR_W-1:0] epc,
   input  logic              redirect_ready,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [4:0]        flush,
   output logic              fetch_hold
`ifdef REDIRECT_STAT_EN
   ,
   output logic [31:0]       stat_bp,
   output logic [31:0]       stat_exp,
   output logic [31:0]       stat_ertn,
   output logic [31:0]       stat_hold
`endif
);

   // Source classes, numerically ordered by priority so a plain compare ranks them.
   localparam logic [1:0] SrcNone = 2'd0;
   localparam logic [1:0] SrcBp   = 2'd1;
   localparam logic [1:0] SrcErtn = 2'd2;
   localparam logic [1:0] SrcExp  = 2'd3;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StFlush    = 2'd1;
   localparam logic [1:0] StRedirect = 2'd2;

   // A mispredict only squashes the younger IF/ID instructions; commit-time
   // events squash everything up to (not including) WB.
   localparam logic [4:0] FlushBp     = 5'b11000;
   localparam logic [4:0] FlushCommit = 5'b11110;

   logic [1:0]        state_q, state_d;
   logic [1:0]        src_q, src_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;

   logic [1:0]        req_src;
   logic [ADDR_W-1:0] req_tgt;
   logic              preempt;
   logic              xfer_done;

   // Pick the single highest-priority request presented this cycle.
   always_comb begin
      req_src = SrcNone;
      req_tgt = '0;
      if (exp_en) begin
         req_src = SrcExp;
         req_tgt = trap_entry;
      end else if (e_ret) begin
         req_src = SrcErtn;
         req_tgt = epc;
      end else if (bp_miss) begin
         req_src = SrcBp;
         req_tgt = bp_target;
      end
   end

   // Only a strictly older event may restart an in-flight redirect; anything
   // equal or lower comes from an instruction that is being flushed anyway.
   assign preempt   = (state_q != StIdle) && (req_src > src_q);
   assign xfer_done = (state_q == StRedirect) && redirect_ready && !preempt;

   // Next-state and latched source/target selection.
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         StIdle: begin
            if (req_src != SrcNone) begin
               state_d = StFlush;
               src_d   = req_src;
               tgt_d   = req_tgt;
            end
         end
         StFlush: begin
            if (preempt) begin
               state_d = StFlush;
               src_d   = req_src;
               tgt_d   = req_tgt;
            end else begin
               state_d = StRedirect;
            end
         end
         StRedirect: begin
            if (preempt) begin
               // Preemption wins over a same-cycle handshake.
               state_d = StFlush;
               src_d   = req_src;
               tgt_d   = req_tgt;
            end else if (redirect_ready) begin
               state_d = StIdle;
               src_d   = SrcNone;
               tgt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            src_d   = SrcNone;
            tgt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         src_q   <= SrcNone;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         tgt_q   <= tgt_d;
      end
   end

   // Outputs decode purely from registered state.
   always_comb begin
      flush          = 5'b00000;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      fetch_hold     = 1'b0;
      unique case (state_q)
         StFlush: begin
            flush      = (src_q == SrcBp) ? FlushBp : FlushCommit;
            fetch_hold = 1'b1;
         end
         StRedirect: begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt_q;
            fetch_hold     = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef REDIRECT_STAT_EN
   logic [31:0] stat_bp_q, stat_exp_q, stat_ertn_q, stat_hold_q;

   // Statistics: completed transfers per source and held-fetch cycles, wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_bp_q   <= '0;
         stat_exp_q  <= '0;
         stat_ertn_q <= '0;
         stat_hold_q <= '0;
      end else begin
         if (xfer_done && (src_q == SrcBp))   stat_bp_q   <= stat_bp_q + 32'd1;
         if (xfer_done && (src_q == SrcExp))  stat_exp_q  <= stat_exp_q + 32'd1;
         if (xfer_done && (src_q == SrcErtn)) stat_ertn_q <= stat_ertn_q + 32'd1;
         if (fetch_hold)                      stat_hold_q <= stat_hold_q + 32'd1;
      end
   end

   assign stat_bp   = stat_bp_q;
   assign stat_exp  = stat_exp_q;
   assign stat_ertn = stat_ertn_q;
   assign stat_hold = stat_hold_q;
`else
   // Transfer completion only feeds the statistics counters.
   logic unused_xfer_done;
   assign unused_xfer_done = xfer_done;
`endif

endmodule

// File: doc/redirect_sequencer.md
REDIRECT_SEQUENCER -- requirements
Module: redirect_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default `ADDR_WIDTH (32), width of all PC/target buses.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports bp_miss (input, 1) and bp_target (input, ADDR_W): branch mispredict resolved in EX, with its correct target.
REQ-005 SHALL have ports exp_en (input, 1) and trap_entry (input, ADDR_W): exception at commit, with its handler address.
REQ-006 SHALL have ports e_ret (input, 1) and epc (input, ADDR_W): ertn at commit, with its return PC.
REQ-007 SHALL have port redirect_ready  input  1  fetch accepts redirect this cycle.
REQ-008 SHALL have outputs redirect_valid (1) and redirect_pc (ADDR_W): new fetch PC offer.
REQ-009 SHALL have output flush  5  per-stage flush; bit4=IF, bit3=ID, bit2=EX, bit1=MEM, bit0=WB.
REQ-010 SHALL have output fetch_hold  1  IF must not advance the PC while set.

Function
REQ-011 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-012 Source priority SHALL be exp_en > e_ret > bp_miss; same-cycle requests capture only the highest.
REQ-013 IDLE with any request SHALL latch source class and target into internal registers, then go to FLUSH next cycle.
REQ-014 FLUSH SHALL last exactly one cycle, driving flush=5'b11110 for exp_en/e_ret and 5'b11000 for bp_miss, then go to REDIRECT.
REQ-015 flush SHALL be 5'b00000 in every state other than FLUSH.
REQ-016 REDIRECT SHALL drive redirect_valid=1 with redirect_pc equal to the latched target, holding both stable until redirect_ready=1.
REQ-017 A redirect_valid & redirect_ready cycle SHALL complete the transfer; the next state is IDLE.
REQ-018 redirect_pc SHALL be 0 whenever redirect_valid=0.
REQ-019 fetch_hold SHALL be 1 in FLUSH and REDIRECT and 0 in IDLE.
REQ-020 In FLUSH or REDIRECT, a request strictly higher in priority than the latched one SHALL overwrite the latched source and target and force FLUSH next cycle; REDIRECT transfer in that cycle SHALL be suppressed (next state FLUSH even if redirect_ready=1).
REQ-021 In FLUSH or REDIRECT, a request of equal or lower priority SHALL be ignored (it belongs to a flushed younger instruction).
REQ-022 In IDLE, redirect_ready SHALL be ignored.
REQ-023 Minimum latency SHALL be: request at cycle N, flush at N+1, redirect_valid at N+2, IDLE at N+3 if redirect_ready=1 at N+2.
REQ-024 A new request in the same cycle a transfer completes SHALL be captured only if strictly higher in priority than the completing one; otherwise it is dropped.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force state IDLE and clear all latched source/target registers, at any point of operation including mid-FLUSH or mid-REDIRECT.
REQ-026 After reset, outputs SHALL be flush=0, redirect_valid=0, redirect_pc=0, fetch_hold=0, and all statistics counters 0.

Configuration
REQ-027 Macro REDIRECT_STAT_EN, when defined, SHALL add outputs stat_bp, stat_exp, stat_ertn (32 bits each) counting completed transfers per source, and stat_hold (32 bits) counting cycles with fetch_hold=1.
REQ-028 All statistics counters SHALL wrap modulo 2^32 and be cleared by reset.
REQ-029 With REDIRECT_STAT_EN undefined, the counters and their ports SHALL be absent and the block's function SHALL be unchanged.

Verification
REQ-030 bp_miss=1, bp_target=0x1C000100 at N, ready tied 1 -> flush=5'b11000 at N+1; redirect_valid=1, pc=0x1C000100 at N+2; IDLE at N+3.
REQ-031 exp_en=1 (trap_entry=0x1C008000) and bp_miss=1 (0x1C000040) same cycle -> flush=5'b11110; redirect_pc=0x1C008000; bp request discarded.
REQ-032 ready=0 for 4 cycles in REDIRECT -> redirect_valid and redirect_pc stable for all 5 cycles, fetch_hold=1 throughout, single transfer on the ready cycle.
REQ-033 In REDIRECT for bp target 0x1C000200, exp_en=1 (0x1C008000) with ready=1 -> no transfer; second flush=5'b11110; redirect_pc=0x1C008000. e_ret in REDIRECT of an exp redirect -> ignored.
REQ-034 rst_n=0 during REDIRECT -> next cycle all outputs 0, state IDLE; the old target is never offered after reset release.
REQ-035 With REDIRECT_STAT_EN defined: 3 bp transfers and 1 exp transfer with one 2-cycle ready stall -> stat_bp=3, stat_exp=1, stat_ertn=0, stat_hold=10.
